host_reg_slave: RTL

// - Responder for host_if (slave modport): decodes host read/write commands into a register bank.
// - Returns read data with rd_vld after a fixed, pipelined latency.
// - Sits between the host master and the datapath: drives cfg registers out, samples status in.

---
 rtl/host_pkg.sv | 14 +
 rtl/host_if.sv | 12 +
 rtl/host_rd_pipe.sv | 33 +++
 rtl/host_reg_slave.sv | 93 +++++++++
 4 files changed

// File: rtl/host_pkg.sv
// rtl/host_pkg.sv - register offsets, error read value and command direction for the host register slave
package host_pkg;
    localparam logic [31:0] ID_OFS      = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS  = 32'h0000_0004;
    localparam logic [31:0] WR_CNT_OFS  = 32'h0000_0008;
    localparam logic [31:0] ERR_CNT_OFS = 32'h0000_000C;
    localparam logic [31:0] CFG_BASE    = 32'h0000_0010;
    localparam logic [31:0] BAD_DATA    = 32'hDEAD_BEEF;

    typedef enum logic {
        HOST_RD = 1'b0,
        HOST_WR = 1'b1
    } host_rw_e;
endpackage

// File: rtl/host_if.sv
// rtl/host_if.sv - single-cycle host command strobe with pipelined read return
interface host_if;
    logic        cmd_vld;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic        rw;
    logic [31:0] data_r;
    logic        rd_vld;

    modport master (output cmd_vld, addr, data_w, rw, input data_r, rd_vld);
    modport slave  (input cmd_vld, addr, data_w, rw, output data_r, rd_vld);
endinterface

// File: rtl/host_rd_pipe.sv
// rtl/host_rd_pipe.sv - fixed-latency valid+data pipeline; last stage holds the most recent returned data
module host_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);
    logic [RD_LAT-1:0]        vld_q;
    logic [RD_LAT-1:0][W-1:0] data_q;

    // Data stages only load behind a valid bit, so the final stage keeps the last read value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) data_q[0] <= in_data;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    assign out_vld  = vld_q[RD_LAT-1];
    assign out_data = data_q[RD_LAT-1];
endmodule

// File: rtl/host_reg_slave.sv
// rtl/host_reg_slave.sv - host command decoder and register bank; HOST_SLV_ERR_CNT_EN adds the ERR_CNT register
module host_reg_slave #(
    parameter int          NUM_CFG = 4,
    parameter int          RD_LAT  = 2,
    parameter logic [31:0] ID_VAL  = 32'h5AB0_0001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    host_if.slave                  host,
    input  logic [31:0]            sts_i,
    output logic [NUM_CFG*32-1:0]  cfg_o
);
    import host_pkg::*;

    localparam int          IW        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [29:0] NUM_CFG_W = 30'(NUM_CFG);

    logic [NUM_CFG-1:0][31:0] cfg_q;
    logic [31:0]              wr_cnt;
    logic [31:0]              cfg_ofs;
    logic                     cfg_hit;
    logic [IW-1:0]            cfg_idx;
    logic [31:0]              rd_data;
    logic                     is_rd;
    logic                     is_wr;
    logic                     wr_acc;

`ifdef HOST_SLV_ERR_CNT_EN
    logic [15:0] err_cnt;
    logic        rd_map;
    logic        bad_op;
`endif

    always_comb begin
        cfg_ofs = host.addr - CFG_BASE;
        cfg_hit = (host.addr[1:0] == 2'b00) && (host.addr >= CFG_BASE) &&
                  (cfg_ofs[31:2] < NUM_CFG_W);
        cfg_idx = cfg_ofs[IW+1:2];
        rd_data = BAD_DATA;
        if (cfg_hit) begin
            rd_data = cfg_q[cfg_idx];
        end else begin
            case (host.addr)
                ID_OFS:      rd_data = ID_VAL;
                STATUS_OFS:  rd_data = sts_i;
                WR_CNT_OFS:  rd_data = wr_cnt;
`ifdef HOST_SLV_ERR_CNT_EN
                ERR_CNT_OFS: rd_data = {16'h0000, err_cnt};
`endif
                default:     rd_data = BAD_DATA;
            endcase
        end
    end

    assign is_rd  = host.cmd_vld && (host_rw_e'(host.rw) == HOST_RD);
    assign is_wr  = host.cmd_vld && (host_rw_e'(host.rw) == HOST_WR);
    assign wr_acc = is_wr && cfg_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= '0;
            wr_cnt <= '0;
        end else if (wr_acc) begin
            cfg_q[cfg_idx] <= host.data_w;
            wr_cnt         <= wr_cnt + 32'd1;
        end
    end

`ifdef HOST_SLV_ERR_CNT_EN
    assign rd_map = cfg_hit ||
                    (host.addr inside {ID_OFS, STATUS_OFS, WR_CNT_OFS, ERR_CNT_OFS});
    // Every write outside CFG is an error, including writes to read-only registers.
    assign bad_op = (is_rd && !rd_map) || (is_wr && !cfg_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (bad_op && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`endif

    host_rd_pipe #(.RD_LAT(RD_LAT), .W(32)) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (is_rd),
        .in_data  (rd_data),
        .out_vld  (host.rd_vld),
        .out_data (host.data_r)
    );

    assign cfg_o = cfg_q;
endmodule
